// File: rtl/mips_alu_md.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier / restoring divider writing the HI/LO registers.
module mips_alu_md #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] op,
  output logic             zeroSignal,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned PW  = 2 * WIDTH + 1;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_MFHI  = 4'd13;
  localparam logic [3:0] OP_MFLO  = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_p;       // MUL: {acc, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0] r_b;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_a;       // raw dividend, returned in HI on divide by zero
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_divz;

  logic             w_accept;
  logic             w_done;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_neg1;
  logic             w_neg2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH:0]   w_mul_sum;
  logic [PW-1:0]    w_mul_step;
  logic [PW-1:0]    w_div_sh;
  logic [WIDTH:0]   w_div_diff;
  logic [PW-1:0]    w_div_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign in_ready   = !rst && (r_state == S_IDLE);
  assign zeroSignal = (op == '0);
  assign w_accept   = in_valid && in_ready;
  assign w_done     = (r_cnt == CW'(WIDTH));
  assign w_is_mul   = (ALUctrl == OP_MULT) || (ALUctrl == OP_MULTU);
  assign w_is_div   = (ALUctrl == OP_DIV)  || (ALUctrl == OP_DIVU);
  assign w_signed   = (ALUctrl == OP_MULT) || (ALUctrl == OP_DIV);
  assign w_neg1     = w_signed && in1[WIDTH-1];
  assign w_neg2     = w_signed && in2[WIDTH-1];
  assign w_mag1     = w_neg1 ? -in1 : in1;
  assign w_mag2     = w_neg2 ? -in2 : in2;

  // Single-cycle result
  always_comb begin
    w_alu = '0;
    case (ALUctrl)
      OP_AND:  w_alu = in1 & in2;
      OP_OR:   w_alu = in1 | in2;
      OP_ADD:  w_alu = in1 + in2;
      OP_SUB:  w_alu = in1 - in2;
      OP_SLT:  w_alu = WIDTH'($signed(in1) < $signed(in2));
      OP_SLL:  w_alu = in1 << in2[SHW-1:0];
      OP_NOR:  w_alu = ~(in1 | in2);
      OP_MFHI: w_alu = hi;
      OP_MFLO: w_alu = lo;
      default: w_alu = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    w_mul_step = r_p[0] ? ({w_mul_sum, r_p[WIDTH-1:0]} >> 1) : (r_p >> 1);
    w_div_sh   = {r_p[2*WIDTH-1:0], 1'b0};
    w_div_diff = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_b};
    w_div_step = w_div_diff[WIDTH] ? w_div_sh
                                   : {w_div_diff, w_div_sh[WIDTH-1:1], 1'b1};
  end

  // Sign fixup applied on the completing edge
  always_comb begin
    w_prod = r_neg_q ? -r_p[2*WIDTH-1:0] : r_p[2*WIDTH-1:0];
    w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
        else if (w_accept && w_is_div) w_state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      op        <= '0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      r_cnt     <= '0;
      r_p       <= '0;
      r_b       <= '0;
      r_a       <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_divz    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul || w_is_div) begin
              r_p     <= {{(WIDTH+1){1'b0}}, w_mag1};
              r_b     <= w_mag2;
              r_a     <= in1;
              r_neg_q <= w_neg1 ^ w_neg2;
              r_neg_r <= w_neg1;
              r_divz  <= (in2 == '0);
              r_cnt   <= '0;
            end else begin
              op        <= w_alu;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (!w_done) begin
            r_p   <= w_mul_step;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            hi        <= w_prod[2*WIDTH-1:WIDTH];
            lo        <= w_prod[WIDTH-1:0];
            op        <= w_prod[WIDTH-1:0];
            out_valid <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_DIV: begin
          if (!w_done) begin
            r_p   <= w_div_step;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            if (r_divz) begin
              hi <= r_a;
              lo <= '1;
              op <= '1;
            end else begin
              hi <= w_rem;
              lo <= w_quo;
              op <= w_quo;
            end
            out_valid <= 1'b1;
            r_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_md.sv
// Bench for mips_alu_md at WIDTH=32 and WIDTH=16, checked against an
// arithmetic reference model of the ALU and HI/LO registers.
module tb_mips_alu_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sel16;
  logic [3:0]  ctrl;
  logic [31:0] a, b;

  logic        rdy32, z32, ov32;
  logic [31:0] op32, hi32, lo32;
  logic        rdy16, z16, ov16;
  logic [15:0] op16, hi16, lo16;

  logic        rdy, z, ov;
  logic [31:0] opv, hiv, lov;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          w;
  logic [31:0] mask;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mips_alu_md #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel16), .in_ready(rdy32),
    .ALUctrl(ctrl), .in1(a), .in2(b), .op(op32), .zeroSignal(z32),
    .out_valid(ov32), .hi(hi32), .lo(lo32));

  mips_alu_md #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel16), .in_ready(rdy16),
    .ALUctrl(ctrl), .in1(a[15:0]), .in2(b[15:0]), .op(op16), .zeroSignal(z16),
    .out_valid(ov16), .hi(hi16), .lo(lo16));

  always_comb begin
    if (sel16) begin
      rdy = rdy16; z = z16; ov = ov16;
      opv = {16'h0, op16}; hiv = {16'h0, hi16}; lov = {16'h0, lo16};
    end else begin
      rdy = rdy32; z = z32; ov = ov32;
      opv = op32; hiv = hi32; lov = lo32;
    end
  end

  // Reference: result of one op; updates model HI/LO for mul/div
  function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] x,
                                         input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] p;
    logic [63:0] t;
    logic [31:0] res;
    sx  = (w == 32) ? longint'($signed(x)) : longint'($signed(x[15:0]));
    sy  = (w == 32) ? longint'($signed(y)) : longint'($signed(y[15:0]));
    res = 32'h0;
    case (c)
      4'd0:  res = x & y;
      4'd1:  res = x | y;
      4'd2:  res = (x + y) & mask;
      4'd3:  res = (x << (y & 32'(w - 1))) & mask;
      4'd6:  res = (x - y) & mask;
      4'd7:  res = (sx < sy) ? 32'd1 : 32'd0;
      4'd12: res = ~(x | y) & mask;
      4'd13: res = m_hi;
      4'd14: res = m_lo;
      4'd8, 4'd9: begin
        if (c == 4'd8) p = 64'(sx * sy);
        else           p = {32'h0, x} * {32'h0, y};
        t    = p >> w;
        m_hi = t[31:0] & mask;
        m_lo = p[31:0] & mask;
        res  = m_lo;
      end
      4'd10, 4'd11: begin
        if (y == 32'h0) begin
          m_hi = x;
          m_lo = mask;
        end else if (c == 4'd10) begin
          q = sx / sy;
          r = sx % sy;
          t = 64'(q); m_lo = t[31:0] & mask;
          t = 64'(r); m_hi = t[31:0] & mask;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
        res = m_lo;
      end
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  // Issue one request and wait for its out_valid; lat = edges after the accepting edge
  task automatic run_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                        input bit noise, output int lat, output bit busy_ok);
    int n;
    busy_ok = 1'b1;
    lat     = -1;
    n       = 0;
    @(negedge clk);
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    ctrl = c; a = x & mask; b = y & mask; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (ov) lat = 0;
    else begin
      for (int k = 1; k <= 100; k++) begin
        @(negedge clk);
        if (rdy) busy_ok = 1'b0;
        if (noise) begin
          in_valid = 1'($urandom % 2);
          ctrl = 4'd2; a = $urandom & mask; b = $urandom & mask;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (ov) begin
          lat = k;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_hi = 32'h0; m_lo = 32'h0;
    n_tests += 6;
    if (opv !== 32'h0) begin n_fail++; $display("FAIL reset_op: got %h expected 0", opv); end
    if (z !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", z); end
    if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
    if (hiv !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hiv); end
    if (lov !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lov); end
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_during: got %b expected 0", rdy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", rdy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  tc [7] = '{4'd2, 4'd6, 4'd7, 4'd6, 4'd3, 4'd12, 4'd15};
    logic [31:0] ta [7] = '{32'd8, 32'd8, 32'd8, 32'd5, 32'd5, 32'd8, 32'd8};
    logic [31:0] tb [7] = '{32'd10, 32'd10, 32'd10, 32'd5, 32'd5, 32'd10, 32'd10};
    logic [31:0] exp;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ctrl = tc[i]; a = ta[i] & mask; b = tb[i] & mask; in_valid = 1'b1;
      exp = ref_op(tc[i], ta[i] & mask, tb[i] & mask);
      @(posedge clk);
      #1;
      n_tests += 3;
      if (ov !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, ov); end
      if (opv !== exp) begin n_fail++; $display("FAIL b2b_op[%0d] ctrl=%0d: got %h expected %h", i, tc[i], opv, exp); end
      if (z !== (exp == 32'h0)) begin n_fail++; $display("FAIL b2b_zero[%0d]: got %b expected %b", i, z, exp == 32'h0); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_tests += 2;
    if (ov !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_end: got %b expected 0", ov); end
    if (opv !== 32'h0) begin n_fail++; $display("FAIL b2b_op_hold: got %h expected 0", opv); end
  endtask

  task automatic test_muldiv();
    logic [3:0]  tc [5];
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [31:0] exp, exp_hi, exp_lo;
    int          lat;
    bit          busy_ok;
    tc = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd10};
    ta = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'h1 << (w - 1)};
    tb = '{32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      exp = ref_op(tc[i], ta[i] & mask, tb[i] & mask);
      run_op(tc[i], ta[i], tb[i], 1'b1, lat, busy_ok);
      n_tests += 5;
      if (lat !== w + 1) begin n_fail++; $display("FAIL md_latency[%0d]: got %0d expected %0d", i, lat, w + 1); end
      if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL md_busy[%0d]: got %b expected 1", i, busy_ok); end
      if (opv !== exp) begin n_fail++; $display("FAIL md_op[%0d]: got %h expected %h", i, opv, exp); end
      if (hiv !== m_hi) begin n_fail++; $display("FAIL md_hi[%0d]: got %h expected %h", i, hiv, m_hi); end
      if (lov !== m_lo) begin n_fail++; $display("FAIL md_lo[%0d]: got %h expected %h", i, lov, m_lo); end
      exp_hi = m_hi;
      exp_lo = m_lo;
      run_op(4'd13, 32'h0, 32'h0, 1'b0, lat, busy_ok);
      n_tests += 2;
      if (lat !== 0) begin n_fail++; $display("FAIL mfhi_latency[%0d]: got %0d expected 0", i, lat); end
      if (opv !== exp_hi) begin n_fail++; $display("FAIL mfhi[%0d]: got %h expected %h", i, opv, exp_hi); end
      run_op(4'd14, 32'h0, 32'h0, 1'b0, lat, busy_ok);
      n_tests++;
      if (opv !== exp_lo) begin n_fail++; $display("FAIL mflo[%0d]: got %h expected %h", i, opv, exp_lo); end
    end
  endtask

  task automatic test_reset_abort();
    bit seen_ov;
    int lat;
    bit busy_ok;
    seen_ov = 1'b0;
    @(negedge clk);
    ctrl = 4'd10; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1 if (ov) seen_ov = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 if (ov) seen_ov = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    #1;
    n_tests += 4;
    if (seen_ov !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b expected 0", seen_ov); end
    if (hiv !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h expected 0", hiv); end
    if (lov !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h expected 0", lov); end
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", rdy); end
    run_op(4'd2, 32'd1, 32'd1, 1'b0, lat, busy_ok);
    n_tests += 2;
    if (lat !== 0) begin n_fail++; $display("FAIL abort_add_latency: got %0d expected 0", lat); end
    if (opv !== 32'd2) begin n_fail++; $display("FAIL abort_add: got %h expected 2", opv); end
  endtask

  task automatic test_random();
    logic [3:0]  c;
    logic [31:0] x, y, exp;
    int          lat, exp_lat;
    bit          busy_ok;
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom % 16);
      x = $urandom & mask;
      case ($urandom % 4)
        0:       y = 32'h0;
        1:       y = $urandom % 9;
        default: y = $urandom & mask;
      endcase
      exp     = ref_op(c, x, y);
      exp_lat = (c >= 4'd8 && c <= 4'd11) ? w + 1 : 0;
      run_op(c, x, y, 1'b1, lat, busy_ok);
      n_tests += 4;
      if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d] ctrl=%0d: got %0d expected %0d", i, c, lat, exp_lat); end
      if (opv !== exp) begin n_fail++; $display("FAIL rnd_op[%0d] ctrl=%0d a=%h b=%h: got %h expected %h", i, c, x, y, opv, exp); end
      if (hiv !== m_hi) begin n_fail++; $display("FAIL rnd_hi[%0d] ctrl=%0d: got %h expected %h", i, c, hiv, m_hi); end
      if (lov !== m_lo) begin n_fail++; $display("FAIL rnd_lo[%0d] ctrl=%0d: got %h expected %h", i, c, lov, m_lo); end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ctrl = 4'd0; a = 32'h0; b = 32'h0;
    sel16 = 1'b0; w = 32; mask = 32'hFFFF_FFFF;
    m_hi = 32'h0; m_lo = 32'h0;
    test_reset();
    test_back_to_back();
    test_muldiv();
    test_reset_abort();
    test_random();
    sel16 = 1'b1; w = 16; mask = 32'h0000_FFFF;
    test_reset();
    test_back_to_back();
    test_muldiv();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
